// File: rtl/carry_skip_addsub_pipe.sv
// Pipelined carry-skip add/subtract: stage k resolves skip block k, so one beat per cycle at any WIDTH.
// Latency NBLK register stages (the last one drives the outputs); a held output freezes the whole pipe and drops in_ready.
module carry_skip_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             op_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic [CNT_W-1:0] skip_cnt_o,
    input  logic             clr_i
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int SW   = CNT_W + 1;

    logic             w_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    logic [WIDTH-1:0] r_a   [NBLK];
    logic [WIDTH-1:0] r_b   [NBLK];
    logic [WIDTH-1:0] r_s   [NBLK];
    logic             r_c   [NBLK];
    logic             r_vld [NBLK];
    logic             r_ovf;
    logic             r_zero;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_a_nxt [NBLK];
    logic [WIDTH-1:0] w_b_nxt [NBLK];
    logic [WIDTH-1:0] w_s_nxt [NBLK];
    logic             w_c_nxt [NBLK];
    logic             w_v_nxt [NBLK];
    logic             w_ovf_nxt;
    logic             w_zero_nxt;

    logic [SW-1:0]    w_pcnt;
    logic [SW-1:0]    w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_en      = ~r_vld[NBLK-1] | out_ready;
    assign in_ready  = w_en;
    assign w_accept  = in_valid & w_en;
    // Subtract is folded into an add at entry so no stage needs op_i.
    assign w_b_eff   = op_i ? ~b_i : b_i;
    assign w_cin_eff = op_i ? ~cin_i : cin_i;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_s;
        logic             w_c;
        logic             w_v;
        logic [BLOCK:0]   w_rip;
        logic             w_p;

        if (k == 0) begin : g_entry
            assign w_a = a_i;
            assign w_b = w_b_eff;
            assign w_s = '0;
            assign w_c = w_cin_eff;
            assign w_v = in_valid;
        end else begin : g_chain
            assign w_a = r_a[k-1];
            assign w_b = r_b[k-1];
            assign w_s = r_s[k-1];
            assign w_c = r_c[k-1];
            assign w_v = r_vld[k-1];
        end

        assign w_rip = {1'b0, w_a[k*BLOCK +: BLOCK]} + {1'b0, w_b[k*BLOCK +: BLOCK]}
                     + {{BLOCK{1'b0}}, w_c};
        assign w_p   = &(w_a[k*BLOCK +: BLOCK] ^ w_b[k*BLOCK +: BLOCK]);

        assign w_a_nxt[k] = w_a;
        assign w_b_nxt[k] = w_b;
        // Slice k of the incoming partial sum is still zero, so OR-ing places the new block.
        assign w_s_nxt[k] = w_s | (WIDTH'(w_rip[BLOCK-1:0]) << (k*BLOCK));
        assign w_c_nxt[k] = w_p ? w_c : w_rip[BLOCK];
        assign w_v_nxt[k] = w_v;
    end

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c_in.
    assign w_ovf_nxt  = w_s_nxt[NBLK-1][WIDTH-1] ^ w_a_nxt[NBLK-1][WIDTH-1]
                      ^ w_b_nxt[NBLK-1][WIDTH-1] ^ w_c_nxt[NBLK-1];
    assign w_zero_nxt = ~|w_s_nxt[NBLK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBLK; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
                r_vld[k] <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < NBLK; k++) begin
                r_a[k]   <= w_a_nxt[k];
                r_b[k]   <= w_b_nxt[k];
                r_s[k]   <= w_s_nxt[k];
                r_c[k]   <= w_c_nxt[k];
                r_vld[k] <= w_v_nxt[k];
            end
            r_ovf  <= w_ovf_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    // All block propagates are visible at entry, so the count is taken on the accept edge.
    always_comb begin
        w_pcnt = '0;
        for (int k = 0; k < NBLK; k++) begin
            w_pcnt = w_pcnt + SW'(&(a_i[k*BLOCK +: BLOCK] ^ w_b_eff[k*BLOCK +: BLOCK]));
        end
    end

    assign w_cnt_sum = {1'b0, r_cnt} + w_pcnt;
    assign w_cnt_nxt = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign out_valid  = r_vld[NBLK-1];
    assign sum_o      = r_s[NBLK-1];
    assign carry_o    = r_c[NBLK-1];
    assign ovf_o      = r_ovf;
    assign zero_o     = r_zero;
    assign skip_cnt_o = r_cnt;
endmodule

// File: tb/tb_carry_skip_addsub_pipe.sv
// Directed bench for carry_skip_addsub_pipe: 16-bit main instance plus a CNT_W=4 instance for saturation.
module tb_carry_skip_addsub_pipe;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, op, out_valid, out_ready, carry, ovf, zero, clr;
    logic [15:0] a, b, sum, cnt;

    logic        in_valid4, in_ready4, out_valid4, carry4, ovf4, zero4, clr4;
    logic [15:0] a4, b4, sum4;
    logic [3:0]  cnt4;

    int          errors = 0;
    int          checks = 0;
    int          exp_cnt = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          d;
    } vec_t;

    carry_skip_addsub_pipe #(.WIDTH(16), .BLOCK(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .op_i(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum_o(sum), .carry_o(carry), .ovf_o(ovf), .zero_o(zero), .skip_cnt_o(cnt), .clr_i(clr)
    );

    carry_skip_addsub_pipe #(.WIDTH(16), .BLOCK(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a_i(a4), .b_i(b4), .cin_i(1'b0), .op_i(1'b0), .out_valid(out_valid4), .out_ready(1'b1),
        .sum_o(sum4), .carry_o(carry4), .ovf_o(ovf4), .zero_o(zero4), .skip_cnt_o(cnt4), .clr_i(clr4)
    );

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
        out_ready = 1'b1; clr = 1'b0; in_valid4 = 1'b0; a4 = '0; b4 = '0; clr4 = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
        checks++; if ({carry, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {carry, ovf, zero}); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL reset_cnt4: got %0d want 0", cnt4); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        exp_cnt = 0;
    endtask

    task automatic test_arith();
        vec_t vecs [6];
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1};
        vecs[1] = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 2};
        vecs[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3};
        vecs[4] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 3};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 2};
        for (int i = 0; i < 6; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arith%0d_in_ready: got %b want 1", i, in_ready); end
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; op = vecs[i].op; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            exp_cnt += vecs[i].d;
            checks++; if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL arith%0d_cnt: got %0d want %0d", i, cnt, exp_cnt); end
            @(posedge clk); @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arith%0d_early_valid: got %b want 0", i, out_valid); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_valid: got %b want 1", i, out_valid); end
            checks++; if (sum !== vecs[i].s) begin errors++; $display("FAIL arith%0d_sum: got %h want %h", i, sum, vecs[i].s); end
            checks++; if ({carry, ovf, zero} !== {vecs[i].c, vecs[i].v, vecs[i].z}) begin
                errors++; $display("FAIL arith%0d_flags(c,v,z): got %b want %b", i, {carry, ovf, zero}, {vecs[i].c, vecs[i].v, vecs[i].z});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          got;
        int          cyc;
        bit          stalled;
        logic [15:0] held;
        got = 0; cyc = 0; stalled = 1'b0; held = '0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    int tries;
                    bit acc;
                    a = 16'(i); b = 16'(i); cin = 1'b0; op = 1'b0; in_valid = 1'b1;
                    tries = 0; acc = 1'b0;
                    while (!acc && tries < 30) begin
                        @(negedge clk); #1; acc = in_ready;
                        @(posedge clk); #1; tries++;
                    end
                    checks++; if (!acc) begin errors++; $display("FAIL bp_accept%0d: got no accept want accept within 30 cycles", i); end
                end
                in_valid = 1'b0;
            end
            begin
                while (got < 6 && cyc < 80) begin
                    @(negedge clk); cyc++;
                    if (out_valid && !stalled) begin
                        stalled = 1'b1; held = sum; out_ready = 1'b0;
                        for (int s = 0; s < 3; s++) begin
                            @(negedge clk); cyc++;
                            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_in_ready: got %b want 0", s, in_ready); end
                            checks++; if (out_valid !== 1'b1 || sum !== held) begin
                                errors++; $display("FAIL bp_stall%0d_hold: got v=%b sum=%h want v=1 sum=%h", s, out_valid, sum, held);
                            end
                        end
                        out_ready = 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        checks++; if (sum !== 16'(2 * (got + 1))) begin
                            errors++; $display("FAIL bp_order%0d: got %0d want %0d", got, sum, 2 * (got + 1));
                        end
                        got++;
                    end
                end
            end
        join
        checks++; if (got != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
        checks++; if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_cnt: got %0d want %0d", cnt, exp_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_skip_counter();
        int exp4;
        exp4 = 0;
        a4 = 16'h5555; b4 = 16'hAAAA;
        for (int j = 0; j < 5; j++) begin
            in_valid4 = 1'b1;
            @(posedge clk); #1;
            exp4 = (exp4 + 4 > 15) ? 15 : exp4 + 4;
            checks++; if (cnt4 !== 4'(exp4)) begin errors++; $display("FAIL sat%0d_cnt: got %0d want %0d", j, cnt4, exp4); end
        end
        clr4 = 1'b1;
        @(posedge clk); #1;
        clr4 = 1'b0;
        checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL clr_with_accept: got %0d want 0", cnt4); end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        checks++; if (cnt4 !== 4'd4) begin errors++; $display("FAIL count_after_clr: got %0d want 4", cnt4); end
    endtask

    task automatic test_reset_in_flight();
        bit seen;
        seen = 1'b0;
        cin = 1'b0; op = 1'b0; b = 16'h0001; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a = 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2; rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid: got %b want 0", out_valid); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL rst_flight_cnt: got %0d want 0", cnt); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_flight_ghost: got out_valid=1 want none"); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_flight_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        a = 16'h0003; b = 16'h0004; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || sum !== 16'h0007) begin
            errors++; $display("FAIL rst_flight_new: got v=%b sum=%h want v=1 sum=0007", out_valid, sum);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_skip_counter();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
